// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the bit counter for a given operand width
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never below 1 so the counter is always a real vector.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit full adder, purely combinational.
// Ports:
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_bit_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: takes two WIDTH-bit operands plus carry-in over a valid/ready
// handshake, adds them LSB-first through one full-adder cell (one bit per clock)
// and returns sum/cout over a second valid/ready handshake.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake (a, b, cin)
//   a, b, cin            : operands and carry-in
//   out_valid, out_ready : result handshake (sum, cout)
//   sum, cout            : (a + b + cin) mod 2^WIDTH and carry-out of bit WIDTH-1
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_sh, a_sh_next;
    logic [WIDTH-1:0]  b_sh, b_sh_next;
    logic [WIDTH-1:0]  sum_sh, sum_sh_next;
    logic              carry, carry_next;
    logic [CntW-1:0]   cnt, cnt_next;
    logic              cell_s;
    logic              cell_c;

    fa_bit_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            a_sh   <= a_sh_next;
            b_sh   <= b_sh_next;
            sum_sh <= sum_sh_next;
            carry  <= carry_next;
            cnt    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        a_sh_next   = a_sh;
        b_sh_next   = b_sh;
        sum_sh_next = sum_sh;
        carry_next  = carry;
        cnt_next    = cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    carry_next = cin;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
                sum_sh_next = {cell_s, sum_sh[WIDTH-1:1]};
                a_sh_next   = a_sh >> 1;
                b_sh_next   = b_sh >> 1;
                carry_next  = cell_c;
                if (cnt == CntLast) begin
                    // Wrap explicitly so a non-power-of-two WIDTH never leaves cnt out of range.
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign cout      = carry;

endmodule
